operand_loader: RTL and testbench

OPERAND_LOADER -- requirements
Module: operand_loader

---
 rtl/operand_loader.sv | 129 ++++++++++++
 tb/tb_operand_loader.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/operand_loader.sv
// Operand loader: captures X then Y for a Booth multiplier,
// pulses start, and watches the core for done or timeout.
module operand_loader #(
  parameter int DW = 32,
  parameter int TIMEOUT = 40,
  localparam int OW = DW / 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_load,
  input  logic signed [OW-1:0] i_data,
  input  logic                 i_done,
  input  logic                 i_clear,
  output logic signed [OW-1:0] o_multiplicand,
  output logic signed [DW:0]   o_init,
  output logic                 o_start,
  output logic                 o_busy,
  output logic                 o_load_ack,
  output logic                 o_err,
  output logic                 o_timeout
);

  localparam int CW =
    (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_MAX =
    CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_Y,
    START,
    BUSY
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic [CW-1:0]       cnt_q;
  logic [CW-1:0]       cnt_d;
  logic signed [OW-1:0] mult_d;
  logic signed [DW:0]   init_d;
  logic                ack_d;
  logic                err_d;
  logic                tmo_d;
  logic                start_d;
  logic                busy_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mult_d  = o_multiplicand;
    init_d  = o_init;
    ack_d   = 1'b0;
    err_d   = o_err;
    tmo_d   = o_timeout;
    if (i_clear) begin
      state_d = IDLE;
      cnt_d   = '0;
      mult_d  = '0;
      init_d  = '0;
      err_d   = 1'b0;
      tmo_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (i_load) begin
            mult_d  = i_data;
            ack_d   = 1'b1;
            state_d = WAIT_Y;
          end
        end
        WAIT_Y: begin
          if (i_load) begin
            init_d  = {{OW{1'b0}}, i_data, 1'b0};
            ack_d   = 1'b1;
            state_d = START;
          end
        end
        START: begin
          if (i_load) err_d = 1'b1;
          cnt_d   = '0;
          state_d = BUSY;
        end
        BUSY: begin
          if (i_load) err_d = 1'b1;
          // done wins over a coincident timeout
          if (i_done) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else if (cnt_q == CNT_MAX) begin
            cnt_d   = '0;
            tmo_d   = 1'b1;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
    start_d = (state_d == START);
    busy_d  = (state_d == START) ||
              (state_d == BUSY);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      o_multiplicand <= '0;
      o_init         <= '0;
      o_start        <= 1'b0;
      o_busy         <= 1'b0;
      o_load_ack     <= 1'b0;
      o_err          <= 1'b0;
      o_timeout      <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      o_multiplicand <= mult_d;
      o_init         <= init_d;
      o_start        <= start_d;
      o_busy         <= busy_d;
      o_load_ack     <= ack_d;
      o_err          <= err_d;
      o_timeout      <= tmo_d;
    end
  end

endmodule

// File: tb/tb_operand_loader.sv
// Bench for operand_loader: transaction-level model compared
// every cycle, plus directed literal expectations.
module tb_operand_loader;

  localparam int DW = 32;
  localparam int OW = 16;
  localparam int TIMEOUT = 40;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 i_load = 1'b0;
  logic signed [OW-1:0] i_data = '0;
  logic                 i_done = 1'b0;
  logic                 i_clear = 1'b0;
  logic signed [OW-1:0] o_multiplicand;
  logic signed [DW:0]   o_init;
  logic                 o_start;
  logic                 o_busy;
  logic                 o_load_ack;
  logic                 o_err;
  logic                 o_timeout;

  operand_loader #(
    .DW(DW),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .i_load(i_load),
    .i_data(i_data),
    .i_done(i_done),
    .i_clear(i_clear),
    .o_multiplicand(o_multiplicand),
    .o_init(o_init),
    .o_start(o_start),
    .o_busy(o_busy),
    .o_load_ack(o_load_ack),
    .o_err(o_err),
    .o_timeout(o_timeout)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  bit checking = 1'b0;

  task automatic chk(input string n,
                     input logic [63:0] a,
                     input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h want %h", n, a, e);
    end
  endtask

  // model: have_x = X held, running = core owns the operands,
  // starting = the single start cycle, elapsed = busy cycles
  bit          have_x = 0;
  bit          running = 0;
  bit          starting = 0;
  int          elapsed = 0;
  logic [15:0] m_mult = '0;
  logic [32:0] m_init = '0;
  bit          m_ack = 0;
  bit          m_err = 0;
  bit          m_tmo = 0;

  always @(posedge clk) begin
    m_ack = 0;
    if (rst || i_clear) begin
      have_x = 0; running = 0; starting = 0;
      elapsed = 0; m_mult = '0; m_init = '0;
      m_err = 0; m_tmo = 0;
    end else if (running) begin
      if (i_load) m_err = 1;
      if (starting) begin
        starting = 0;
        elapsed = 0;
      end else begin
        elapsed++;
        if (i_done) running = 0;
        else if (elapsed == TIMEOUT) begin
          m_tmo = 1;
          running = 0;
        end
      end
    end else if (i_load) begin
      m_ack = 1;
      if (!have_x) begin
        m_mult = i_data;
        have_x = 1;
      end else begin
        m_init = 33'(int'($unsigned(i_data)) * 2);
        have_x = 0;
        running = 1;
        starting = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      chk("mult", $unsigned(o_multiplicand), m_mult);
      chk("init", $unsigned(o_init), m_init);
      chk("start", o_start, running && starting);
      chk("busy", o_busy, running);
      chk("ack", o_load_ack, m_ack);
      chk("err", o_err, m_err);
      chk("tmo", o_timeout, m_tmo);
    end
  end

  task automatic step(input bit ld, input logic [15:0] d,
                      input bit dn, input bit cl);
    i_load = ld;
    i_data = d;
    i_done = dn;
    i_clear = cl;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 16'h0, 0, 0);
  endtask

  initial begin
    step(0, 16'h0, 0, 0);
    checking = 1'b1;
    step(1, 16'h1111, 1, 0);
    chk("rst_mult", $unsigned(o_multiplicand), 0);
    chk("rst_init", $unsigned(o_init), 0);
    chk("rst_flags", {o_start, o_busy, o_load_ack,
                      o_err, o_timeout}, 0);
    rst = 1'b0;
    // load on first cycle after release, X=3, Y=-2
    step(1, 16'h0003, 0, 0);
    chk("x_ack", o_load_ack, 1);
    chk("x_val", $unsigned(o_multiplicand), 16'h0003);
    chk("x_nostart", o_start, 0);
    step(1, 16'hFFFE, 0, 0);
    chk("y_ack", o_load_ack, 1);
    chk("y_init", $unsigned(o_init), 33'h0_0001_FFFC);
    chk("y_start", o_start, 1);
    idle(1);
    chk("start_once", o_start, 0);
    chk("busy_on", o_busy, 1);
    chk("ack_once", o_load_ack, 0);
    idle(5);
    step(0, 16'h0, 1, 0);
    chk("done_busy", o_busy, 0);
    chk("done_tmo", o_timeout, 0);
    step(1, 16'h0007, 0, 0);
    chk("x2_ack", o_load_ack, 1);
    chk("x2_val", $unsigned(o_multiplicand), 16'h0007);
    step(1, 16'h0005, 0, 0);
    chk("y2_init", $unsigned(o_init), 33'h0_0000_000A);
    // load in START sets err, dropped
    step(1, 16'h1234, 0, 0);
    chk("start_err", o_err, 1);
    step(1, 16'h7FFF, 0, 0);
    chk("busy_err", o_err, 1);
    chk("busy_noack", o_load_ack, 0);
    chk("busy_init", $unsigned(o_init), 33'h0_0000_000A);
    idle(38);
    chk("pre_tmo_busy", o_busy, 1);
    chk("pre_tmo", o_timeout, 0);
    idle(1);
    chk("tmo_set", o_timeout, 1);
    chk("tmo_idle", o_busy, 0);
    step(1, 16'h0001, 0, 0);
    step(1, 16'h0002, 0, 0);
    idle(2);
    step(0, 16'h0, 1, 0);
    chk("tmo_sticky", o_timeout, 1);
    step(0, 16'h0, 0, 1);
    chk("clr_err", o_err, 0);
    chk("clr_tmo", o_timeout, 0);
    chk("clr_mult", $unsigned(o_multiplicand), 0);
    chk("clr_init", $unsigned(o_init), 0);
    // done during START ignored; done+timeout -> done
    step(1, 16'h0004, 0, 0);
    step(1, 16'hFFFF, 0, 0);
    chk("neg_init", $unsigned(o_init), 33'h0_0001_FFFE);
    step(0, 16'h0, 1, 0);
    chk("start_done_ign", o_busy, 1);
    idle(39);
    chk("edge_busy", o_busy, 1);
    step(0, 16'h0, 1, 0);
    chk("edge_busy_off", o_busy, 0);
    chk("edge_tmo", o_timeout, 0);
    step(1, 16'h0009, 0, 1);
    chk("clr_ld_ack", o_load_ack, 0);
    chk("clr_ld_mult", $unsigned(o_multiplicand), 0);
    // reset in WAIT_Y discards X
    step(1, 16'h8000, 0, 0);
    chk("x8000", $unsigned(o_multiplicand), 16'h8000);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    step(1, 16'h0005, 0, 0);
    chk("rst_y_as_x", $unsigned(o_multiplicand), 16'h0005);
    chk("rst_nostart", o_start, 0);
    idle(1);
    chk("rst_nobusy", o_busy, 0);
    // mixed traffic checked by the model
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 149) == 0);
      step(bit'($urandom_range(0, 1)),
           16'($urandom),
           ($urandom_range(0, 29) == 0),
           ($urandom_range(0, 79) == 0));
    end
    rst = 1'b0;
    idle(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
